// File: rtl/msfsm_arb_pkg.sv
// Shared state encoding and error-flag bit positions for the MSFSM channel arbiter.
package msfsm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACK,
    ST_RTZ
  } arb_state_e;

  localparam int ERR_AO       = 0;
  localparam int ERR_WITHDRAW = 1;
  localparam int ERR_TIMEOUT  = 2;

endpackage

// File: rtl/msfsm_rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_i, with wrap-around.
module msfsm_rr_pick
  import msfsm_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] cand;

  // Scan from the farthest candidate down so the nearest one after last_i wins.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int i = N; i >= 1; i--) begin
      cand = IW'((int'(last_i) + i) % N);
      if (req_i[cand]) begin
        idx_o   = cand;
        valid_o = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign onehot_o[gi] = valid_o && (idx_o == IW'(gi));
  end

endmodule

// File: rtl/msfsm_channel_arbiter.sv
// Round-robin arbiter sharing one 4-phase output channel among N 4-phase requesters,
// with registered levels, one-cycle event strobes and sticky error flags.
module msfsm_channel_arbiter
  import msfsm_arb_pkg::*;
#(
  parameter int N       = 2,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] Ri,
  output logic [N-1:0] Ai,
  output logic         Ro,
  input  logic         Ao,
  output logic [N-1:0] grant,
  output logic         Ro_PLUS,
  output logic         Ro_MINUS,
  output logic         Ai_PLUS,
  output logic         Ai_MINUS,
  output logic [2:0]   err
);

  localparam int              IW     = $clog2(N);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  arb_state_e      state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [N-1:0]    ai_q, ai_d;
  logic            ro_q, ro_d;
  logic            ro_plus_q, ro_plus_d, ro_minus_q, ro_minus_d;
  logic            ai_plus_q, ai_plus_d, ai_minus_q, ai_minus_d;
  logic [IW-1:0]   k_q, k_d, last_q, last_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [2:0]      err_q, err_d;
  logic            wait_tick;

  logic [N-1:0]    pick_onehot;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;

  msfsm_rr_pick #(.N(N), .IW(IW)) u_pick (
    .req_i    (Ri),
    .last_i   (last_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ai_d       = ai_q;
    ro_d       = ro_q;
    k_d        = k_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    ro_plus_d  = 1'b0;
    ro_minus_d = 1'b0;
    ai_plus_d  = 1'b0;
    ai_minus_d = 1'b0;
    wait_tick  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Ao) err_d[ERR_AO] = 1'b1;
        if (pick_valid) begin
          grant_d   = pick_onehot;
          k_d       = pick_idx;
          ro_d      = 1'b1;
          ro_plus_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (Ao) begin
          ai_d[k_q] = 1'b1;
          ai_plus_d = 1'b1;
          state_d   = ST_ACK;
        end else begin
          wait_tick = 1'b1;
          if (!Ri[k_q]) err_d[ERR_WITHDRAW] = 1'b1;
        end
      end
      ST_ACK: begin
        if (!Ao) err_d[ERR_AO] = 1'b1;
        if (!Ri[k_q]) begin
          ro_d       = 1'b0;
          ro_minus_d = 1'b1;
          cnt_d      = '0;
          state_d    = ST_RTZ;
        end
      end
      ST_RTZ: begin
        // One extra RTZ cycle after Ai- keeps the next Ro+ at least two cycles away.
        if (!ai_q[k_q]) begin
          state_d = ST_IDLE;
        end else if (!Ao) begin
          ai_d[k_q]  = 1'b0;
          ai_minus_d = 1'b1;
          grant_d    = '0;
          last_d     = k_q;
        end else begin
          wait_tick = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (TIMEOUT != 0 && wait_tick) begin
      if (cnt_q != TO_LIM) cnt_d = cnt_q + 1'b1;
      if (cnt_q == TO_LIM - 1'b1) err_d[ERR_TIMEOUT] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      ai_q       <= '0;
      ro_q       <= 1'b0;
      ro_plus_q  <= 1'b0;
      ro_minus_q <= 1'b0;
      ai_plus_q  <= 1'b0;
      ai_minus_q <= 1'b0;
      k_q        <= '0;
      last_q     <= IW'(N - 1);
      cnt_q      <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ai_q       <= ai_d;
      ro_q       <= ro_d;
      ro_plus_q  <= ro_plus_d;
      ro_minus_q <= ro_minus_d;
      ai_plus_q  <= ai_plus_d;
      ai_minus_q <= ai_minus_d;
      k_q        <= k_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign Ai       = ai_q;
  assign Ro       = ro_q;
  assign grant    = grant_q;
  assign Ro_PLUS  = ro_plus_q;
  assign Ro_MINUS = ro_minus_q;
  assign Ai_PLUS  = ai_plus_q;
  assign Ai_MINUS = ai_minus_q;
  assign err      = err_q;

endmodule
